alu_multicycle: RTL

- Parametrised successor to the single-cycle datapath ALU.
- Keeps the existing 4-bit ALUOp encoding and single-cycle operations, now registered behind a valid/ready handshake.
- Adds iterative unsigned multiply and divide with HI/LO results, for MIPS MULTU/DIVU support.
- Sits between the register-read stage and writeback; the control unit stalls on in_ready.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/muldiv_iter.sv | 99 +++++++++
 rtl/alu_multicycle.sv | 121 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op codes, handshake FSM states and mul/div kind encoding
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_NOR   = 4'b0011;
  localparam logic [3:0] OP_OR    = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_SUBU  = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_MULT  = 4'b1101;
  localparam logic [3:0] OP_DIV   = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic is_div;
    logic is_signed;
  } muldiv_kind_t;

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative shift-add multiplier / restoring divider with HI/LO registers
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  muldiv_kind_t     kind,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0]   hi_q, lo_q, b_q, hi_n, lo_n, a_mag, b_mag;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q, fix_q, neg_q, neg_r_q, a_neg, b_neg, last;
  muldiv_kind_t       kind_q;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod_neg;

  // Signed ops run on magnitudes; the sign is restored in one trailing fix cycle.
  assign a_neg = kind.is_signed & a[WIDTH-1];
  assign b_neg = kind.is_signed & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign last  = busy_q && (cnt_q == CNT_LAST);

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, b_q};
    prod_neg = -{hi_q, lo_q};
    if (kind_q.is_div) begin
      if (!div_diff[WIDTH]) begin
        hi_n = div_diff[WIDTH-1:0];
        lo_n = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = div_sh[WIDTH-1:0];
        lo_n = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      fix_q   <= 1'b0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      kind_q  <= '0;
    end else if (start) begin
      hi_q    <= '0;
      lo_q    <= a_mag;
      b_q     <= b_mag;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      fix_q   <= 1'b0;
      kind_q  <= kind;
      neg_q   <= a_neg ^ b_neg;
      neg_r_q <= a_neg;
    end else if (busy_q) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last) begin
        busy_q <= 1'b0;
        fix_q  <= kind_q.is_signed;
      end
    end else if (fix_q) begin
      fix_q <= 1'b0;
      if (kind_q.is_div) begin
        if (neg_q)   lo_q <= -lo_q;
        if (neg_r_q) hi_q <= -hi_q;
      end else if (neg_q) begin
        {hi_q, lo_q} <= prod_neg;
      end
    end
  end

  assign busy = busy_q | fix_q;
  assign done = (last && !kind_q.is_signed) || fix_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - registered ALU with iterative mul/div behind valid/ready; ALU_SIGNED_MULDIV_EN adds MULT/DIV
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_op,
  input  logic [WIDTH-1:0]   data1,
  input  logic [WIDTH-1:0]   data2,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTH-1:0]   hi_result,
  output logic               zero,
  output logic               div_by_zero,
  output logic               illegal_op
);
  state_t           state_q, state_d;
  muldiv_kind_t     kind;
  logic [WIDTH-1:0] alu_res, result_q, hi_q, md_hi, md_lo;
  logic             accept, start, op_muldiv, op_illegal, dz;
  logic             md_sel_q, dbz_q, ill_q, md_busy, md_done;

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign dz       = op_muldiv && kind.is_div && (data2 == '0);
  assign start    = accept && op_muldiv && !dz;

  always_comb begin
    alu_res    = '0;
    op_illegal = 1'b0;
    op_muldiv  = 1'b0;
    kind       = '0;
    case (alu_op)
      OP_ADD:          alu_res = data1 + data2;
      OP_AND:          alu_res = data1 & data2;
      OP_NOR:          alu_res = ~(data1 | data2);
      OP_OR:           alu_res = data1 | data2;
      OP_SLL:          alu_res = data1 << shamt;
      OP_SRL:          alu_res = data1 >> shamt;
      OP_SLT:          alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
      OP_SLTU:         alu_res = {{(WIDTH-1){1'b0}}, (data1 < data2)};
      OP_SUB, OP_SUBU: alu_res = data1 - data2;
      OP_MULTU:        op_muldiv = 1'b1;
      OP_DIVU: begin
        op_muldiv   = 1'b1;
        kind.is_div = 1'b1;
      end
`ifdef ALU_SIGNED_MULDIV_EN
      OP_MULT: begin
        op_muldiv      = 1'b1;
        kind.is_signed = 1'b1;
      end
      OP_DIV: begin
        op_muldiv      = 1'b1;
        kind.is_div    = 1'b1;
        kind.is_signed = 1'b1;
      end
`endif
      default:         op_illegal = 1'b1;
    endcase
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .kind  (kind),
    .a     (data1),
    .b     (data2),
    .busy  (md_busy),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = start ? ST_BUSY : ST_DONE;
      ST_BUSY: if (md_done || !md_busy) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Mul/div results are read straight from the idle engine, which holds them until the next start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      hi_q     <= '0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
      md_sel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        md_sel_q <= start;
        result_q <= dz ? '1 : alu_res;
        hi_q     <= dz ? data1 : '0;
        dbz_q    <= dz;
        ill_q    <= op_illegal;
      end
    end
  end

  assign out_valid   = (state_q == ST_DONE);
  assign result      = md_sel_q ? md_lo : result_q;
  assign hi_result   = md_sel_q ? md_hi : hi_q;
  assign zero        = out_valid && (result == '0);
  assign div_by_zero = out_valid && dbz_q;
  assign illegal_op  = out_valid && ill_q;

endmodule
